// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result FIFOs feeding one registered broadcast per cycle.
// Latency: an uncontested accept in cycle t is broadcast in cycle t+1; each lost arbitration adds a cycle.
// Backpressure: src_ready[i] is !full[i] from registered state only; rdy_in=0 freezes everything.
//
// Ports: clk_in/rst_in (sync, active-high), rdy_in (pause), flush (drop everything pending),
//        src_valid/src_ready/src_rob_id/src_value (packed per source, source i at [i*W +: W]),
//        cdb_valid/cdb_rob_id/cdb_value/cdb_src (registered broadcast).
// Build option: define CDB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.

`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif

// Generic circular FIFO with occupancy count.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: caller must not push when full; en=0 holds all state, clr empties it.
module cdb_fifo #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         en,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         empty,
    output logic         full
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;   // one extra bit so full and empty are distinguishable

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (en) begin
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (!push && pop) count <= count - 1'b1;
            end
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_in) begin
        if (!rst_in && en && !clr && push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
endmodule

module cdb_arbiter #(
    parameter int NUM_SRC       = 3,
    parameter int FIFO_SIZE_BIT = 2,
    parameter int ROB_ID_BIT    = `ROB_WIDTH_BIT
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          flush,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC*ROB_ID_BIT-1:0] src_rob_id,
    input  logic [NUM_SRC*32-1:0]         src_value,
    output logic                          cdb_valid,
    output logic [ROB_ID_BIT-1:0]         cdb_rob_id,
    output logic [31:0]                   cdb_value,
    output logic [$clog2(NUM_SRC)-1:0]    cdb_src
);
    localparam int SW = $clog2(NUM_SRC);
    localparam int W  = ROB_ID_BIT + 32;   // {tag, value}

    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] accept;
    logic [NUM_SRC-1:0] cand_vld;
    logic [NUM_SRC-1:0] grant_oh;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [W-1:0]       inc_dat  [NUM_SRC];
    logic [W-1:0]       head_dat [NUM_SRC];
    logic [W-1:0]       cand_dat [NUM_SRC];

    logic               grant_vld;
    logic [SW-1:0]      grant_idx;
    logic [W-1:0]       win_dat;

    assign src_ready = ~full;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign inc_dat[gi]  = {src_rob_id[gi*ROB_ID_BIT +: ROB_ID_BIT], src_value[gi*32 +: 32]};
        assign accept[gi]   = src_valid[gi] & ~full[gi];
        // Queued head always goes first so a new result cannot overtake older ones.
        assign cand_vld[gi] = ~empty[gi] | accept[gi];
        assign cand_dat[gi] = empty[gi] ? inc_dat[gi] : head_dat[gi];
        assign grant_oh[gi] = grant_vld && (grant_idx == SW'(gi));
        // A result granted straight from the input never enters the FIFO.
        assign push[gi]     = accept[gi] & ~(grant_oh[gi] & empty[gi]);
        assign pop[gi]      = grant_oh[gi] & ~empty[gi];

        cdb_fifo #(.W(W), .AW(FIFO_SIZE_BIT)) u_fifo (
            .clk_in   (clk_in),
            .rst_in   (rst_in),
            .en       (rdy_in),
            .clr      (flush),
            .push     (push[gi]),
            .push_dat (inc_dat[gi]),
            .pop      (pop[gi]),
            .head_dat (head_dat[gi]),
            .empty    (empty[gi]),
            .full     (full[gi])
        );
    end

`ifdef CDB_FIXED_PRIO_EN
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!grant_vld && cand_vld[k]) begin
                grant_vld = 1'b1;
                grant_idx = SW'(k);
            end
        end
    end
`else
    logic [SW-1:0] rr_ptr;
    int unsigned   scan_idx;

    // Search upward from rr_ptr, wrapping at NUM_SRC.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NUM_SRC;
            if (!grant_vld && cand_vld[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = SW'(scan_idx);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rr_ptr <= '0;
        end else if (rdy_in) begin
            if (flush)
                rr_ptr <= '0;
            else if (grant_vld)
                rr_ptr <= (grant_idx == SW'(NUM_SRC-1)) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    assign win_dat = cand_dat[grant_idx];

    // Tag and value hold across idle cycles; only cdb_valid drops.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cdb_valid  <= 1'b0;
            cdb_rob_id <= '0;
            cdb_value  <= '0;
            cdb_src    <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                cdb_valid <= 1'b0;
            end else begin
                cdb_valid <= grant_vld;
                if (grant_vld) begin
                    cdb_rob_id <= win_dat[32 +: ROB_ID_BIT];
                    cdb_value  <= win_dat[31:0];
                    cdb_src    <= grant_idx;
                end
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
    localparam int NS = 3;
    localparam int RW = 4;
    localparam int DEPTH = 4;

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b1;
    logic            rdy_in = 1'b1;
    logic            flush  = 1'b0;
    logic [NS-1:0]   src_valid = '0;
    logic [NS-1:0]   src_ready;
    logic [NS*RW-1:0] src_rob_id = '0;
    logic [NS*32-1:0] src_value  = '0;
    logic            cdb_valid;
    logic [RW-1:0]   cdb_rob_id;
    logic [31:0]     cdb_value;
    logic [1:0]      cdb_src;

    cdb_arbiter #(.NUM_SRC(NS), .FIFO_SIZE_BIT(2), .ROB_ID_BIT(RW)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .flush      (flush),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_rob_id (src_rob_id),
        .src_value  (src_value),
        .cdb_valid  (cdb_valid),
        .cdb_rob_id (cdb_rob_id),
        .cdb_value  (cdb_value),
        .cdb_src    (cdb_src)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    // Reference model: one queue of pending results per source.
    typedef struct packed {
        logic [RW-1:0] tag;
        logic [31:0]   val;
    } ent_t;

    ent_t        q0[$], q1[$], q2[$];
    int          m_rr = 0;
    logic        m_valid = 1'b0;
    logic [RW-1:0] m_tag = '0;
    logic [31:0] m_val = '0;
    logic [1:0]  m_src = '0;
    logic [2:0]  acc_last = '0;
    bit          known = 0;
    bit          logging = 0;
    logic [RW-1:0] alu_seen[$];
    logic [RW-1:0] alu_sent[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
            $error("%s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic qpush(input int i, input ent_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic qpop(input int i, output ent_t e);
        case (i)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic qclear();
        q0.delete(); q1.delete(); q2.delete();
    endtask

    task automatic drive(input logic [2:0] v, input logic [RW-1:0] t0, t1, t2,
                         input logic [31:0] d0, d1, d2);
        src_valid  = v;
        src_rob_id = {t2, t1, t0};
        src_value  = {d2, d1, d0};
    endtask

    task automatic drive_rand(input logic [2:0] v);
        drive(v, RW'($urandom), RW'($urandom), RW'($urandom), $urandom, $urandom, $urandom);
    endtask

    // One clock: predict with the queue model, advance, then compare.
    // Model rule: accepted results join their queue, then the winner's oldest entry is broadcast.
    task automatic tick();
        logic [2:0] exp_rdy;
        ent_t e;
        int   g;
        int   s;
        bit   was_rst;
        for (int i = 0; i < NS; i++) exp_rdy[i] = (qsize(i) < DEPTH);
        if (known) chk("src_ready", 32'(src_ready), 32'(exp_rdy));
        acc_last = '0;
        was_rst  = rst_in;
        if (rst_in) begin
            qclear();
            m_valid = 1'b0; m_tag = '0; m_val = '0; m_src = '0; m_rr = 0;
        end else if (!rdy_in) begin
            // everything holds
        end else if (flush) begin
            qclear();
            m_valid = 1'b0; m_rr = 0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (src_valid[i] && exp_rdy[i]) begin
                    e.tag = src_rob_id[i*RW +: RW];
                    e.val = src_value[i*32 +: 32];
                    qpush(i, e);
                    acc_last[i] = 1'b1;
                end
            end
            g = -1;
            for (int k = 0; k < NS; k++) begin
`ifdef CDB_FIXED_PRIO_EN
                s = k;
`else
                s = (m_rr + k) % NS;
`endif
                if (g < 0 && qsize(s) > 0) g = s;
            end
            if (g >= 0) begin
                qpop(g, e);
                m_valid = 1'b1; m_tag = e.tag; m_val = e.val; m_src = g[1:0];
                m_rr = (g + 1) % NS;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk_in);
        #1;
        if (was_rst) known = 1;
        if (known) begin
            chk("cdb_valid", 32'(cdb_valid), 32'(m_valid));
            chk("cdb_rob_id", 32'(cdb_rob_id), 32'(m_tag));
            chk("cdb_value", cdb_value, m_val);
            if (m_valid) chk("cdb_src", 32'(cdb_src), 32'(m_src));
        end
        if (logging && cdb_valid && cdb_src == 2'd1) alu_seen.push_back(cdb_rob_id);
    endtask

    initial begin
        int nvalid;
        int alu_tag;
        bit saw_full;
        logic [RW+32:0] snap;

        // Reset
        rst_in = 1'b1;
        tick(); tick();
        rst_in = 1'b0;
        chk("reset_cdb_valid", 32'(cdb_valid), 32'd0);
        chk("reset_src_ready", 32'(src_ready), 32'h7);

        // Single uncontested result on the ALU
        drive(3'b010, 4'd0, 4'd5, 4'd0, 32'h0, 32'h1234, 32'h0);
        tick();
        chk("single_valid", 32'(cdb_valid), 32'd1);
        chk("single_rob", 32'(cdb_rob_id), 32'd5);
        chk("single_value", cdb_value, 32'h1234);
        chk("single_src", 32'(cdb_src), 32'd1);
        drive(3'b000, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0);
        tick();
        chk("single_idle", 32'(cdb_valid), 32'd0);

        // Three-way collision from rr_ptr=0 (flush returns the pointer to 0)
        flush = 1'b1; tick(); flush = 1'b0;
        drive(3'b111, 4'd1, 4'd2, 4'd3, 32'hA1, 32'hA2, 32'hA3);
        tick();
        chk("coll_first", 32'(cdb_rob_id), 32'd1);
        drive(3'b000, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0);
        tick();
        chk("coll_second", 32'(cdb_rob_id), 32'd2);
        tick();
        chk("coll_third", 32'(cdb_rob_id), 32'd3);
        tick();
        chk("coll_done", 32'(cdb_valid), 32'd0);

        // Backpressure: ALU streams tags 0..7 against busy neighbours
        logging = 1; alu_tag = 0; saw_full = 0;
        for (int c = 0; c < 80 && alu_tag < 8; c++) begin
            drive_rand({c < 20, 1'b1, c < 20});
            src_rob_id[RW +: RW] = RW'(alu_tag);
            if (!src_ready[1]) saw_full = 1;
            tick();
            if (acc_last[1]) begin
                alu_sent.push_back(RW'(alu_tag));
                alu_tag++;
            end
        end
        chk("bp_all_accepted", 32'(alu_tag), 32'd8);
        chk("bp_saw_full", 32'(saw_full), 32'd1);
        drive(3'b000, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0);
        for (int c = 0; c < 16; c++) tick();
        logging = 0;
        chk("bp_count", 32'(alu_seen.size()), 32'(alu_sent.size()));
        for (int i = 0; i < alu_sent.size() && i < alu_seen.size(); i++)
            chk("bp_order", 32'(alu_seen[i]), 32'(alu_sent[i]));

        // Flush with entries queued in source 2
        for (int c = 0; c < 10 && qsize(2) < 3; c++) begin
            drive_rand(3'b111);
            src_rob_id[2*RW +: RW] = RW'(4'hA + c);
            tick();
        end
        chk("flush_prefill", 32'(qsize(2) >= 3), 32'd1);
        flush = 1'b1;
        drive_rand(3'b111);
        tick();
        flush = 1'b0;
        chk("flush_valid", 32'(cdb_valid), 32'd0);
        chk("flush_ready", 32'(src_ready), 32'h7);
        drive(3'b000, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0);
        nvalid = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (cdb_valid) nvalid++;
        end
        chk("flush_no_stale", 32'(nvalid), 32'd0);

        // Pause with two entries queued
        drive_rand(3'b111);
        tick();
        snap = {cdb_valid, cdb_rob_id, cdb_value};
        rdy_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_rand(3'($urandom));
            tick();
            chk("pause_hold", 32'({cdb_valid, cdb_rob_id, cdb_value} == snap), 32'd1);
        end
        rdy_in = 1'b1;
        drive(3'b000, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0);
        for (int c = 0; c < 4; c++) tick();

        // Random traffic with occasional flush and pause
        for (int c = 0; c < 400; c++) begin
            drive_rand(3'($urandom));
            flush  = ($urandom_range(0, 31) == 0);
            rdy_in = ($urandom_range(0, 7) != 0);
            tick();
        end
        flush = 1'b0; rdy_in = 1'b1;

        // Reset with full FIFOs
        for (int c = 0; c < 12; c++) begin
            drive_rand(3'b111);
            tick();
        end
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        chk("rst_mid_valid", 32'(cdb_valid), 32'd0);
        chk("rst_mid_ready", 32'(src_ready), 32'h7);
        drive(3'b000, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0);
        nvalid = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (cdb_valid) nvalid++;
        end
        chk("rst_no_stale", 32'(nvalid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
